// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and shift kinds.
package alu_seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Encodings match op[1:0] of the shift opcodes.
  typedef enum logic [1:0] {
    SK_SHL = 2'b00,
    SK_SHR = 2'b01,
    SK_ASR = 2'b10,
    SK_ROR = 2'b11
  } shift_kind_t;

  localparam logic [3:0] OP_TFR_A = 4'b0000;
  localparam logic [3:0] OP_INC   = 4'b0001;
  localparam logic [3:0] OP_SBC   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0011;
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_ADC   = 4'b0101;
  localparam logic [3:0] OP_TFR_B = 4'b0110;
  localparam logic [3:0] OP_DEC   = 4'b0111;
  localparam logic [3:0] OP_AND   = 4'b1000;
  localparam logic [3:0] OP_OR    = 4'b1001;
  localparam logic [3:0] OP_XOR   = 4'b1010;
  localparam logic [3:0] OP_NOT   = 4'b1011;
  localparam logic [3:0] OP_SHL   = 4'b1100;
  localparam logic [3:0] OP_SHR   = 4'b1101;
  localparam logic [3:0] OP_ASR   = 4'b1110;
  localparam logic [3:0] OP_ROR   = 4'b1111;

endpackage

// File: rtl/alu_seq_comb.sv
// Single-cycle ALU datapath: adder-based arithmetic and bitwise logic with carry/overflow.
module alu_seq_comb
  import alu_seq_pkg::*;
#(
  parameter int DSIZE  = 16,
  parameter int OPSIZE = 4
) (
  input  logic [OPSIZE-1:0] op,
  input  logic [DSIZE-1:0]  a,
  input  logic [DSIZE-1:0]  b,
  output logic [DSIZE-1:0]  f,
  output logic              c,
  output logic              v
);

  localparam int MSB = DSIZE - 1;

  logic [DSIZE-1:0] b_op;
  logic             cin;
  logic [DSIZE:0]   sum;

  // Every arithmetic op is a + B' + cin; only the B' source and carry-in vary.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    b_op = '0;
    cin  = 1'b0;
    case (op)
      OP_INC:  cin = 1'b1;
      OP_SBC:  b_op = ~b;
      OP_SUB:  begin b_op = ~b; cin = 1'b1; end
      OP_ADD:  b_op = b;
      OP_ADC:  begin b_op = b; cin = 1'b1; end
      OP_DEC:  b_op = '1;
      default: ;
    endcase
  end

  assign sum = {1'b0, a} + {1'b0, b_op} + {{DSIZE{1'b0}}, cin};

  always_comb begin
    f = '0;
    c = 1'b0;
    v = 1'b0;
    if (!op[3]) begin
      if (op == OP_TFR_B) begin
        f = b;
      end else begin
        f = sum[DSIZE-1:0];
        c = sum[DSIZE];
        v = (a[MSB] == b_op[MSB]) && (sum[MSB] != a[MSB]);
      end
    end else begin
      // Also covers op 11xx when the shifter is not built.
      case (op[1:0])
        2'b00:   f = a & b;
        2'b01:   f = a | b;
        2'b10:   f = a ^ b;
        default: f = ~a;
      endcase
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes and an optional bit-serial shifter,
// built only when ALU_SEQ_SHIFT_EN is defined (otherwise op 11xx is plain logic).
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int DSIZE  = 16,
  parameter int OPSIZE = 4,
  parameter int SHW    = $clog2(DSIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPSIZE-1:0] op,
  input  logic [DSIZE-1:0]  data_a,
  input  logic [DSIZE-1:0]  data_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DSIZE-1:0]  f,
  output logic              n,
  output logic              z,
  output logic              c,
  output logic              v,
  output logic              busy
);

  if (OPSIZE != 4 || DSIZE < 4 || (DSIZE & (DSIZE - 1)) != 0 || SHW != $clog2(DSIZE))
  begin : g_param_check
    $error("alu_seq: unsupported DSIZE/OPSIZE/SHW combination");
  end

  logic             accept;
  logic             load;
  logic [DSIZE-1:0] comb_f;
  logic             comb_c;
  logic             comb_v;
  logic [DSIZE-1:0] res_f;
  logic             res_c;
  logic             res_v;

  alu_seq_comb #(
    .DSIZE  (DSIZE),
    .OPSIZE (OPSIZE)
  ) u_comb (
    .op (op),
    .a  (data_a),
    .b  (data_b),
    .f  (comb_f),
    .c  (comb_c),
    .v  (comb_v)
  );

  assign accept = in_valid && in_ready;

`ifdef ALU_SEQ_SHIFT_EN
  state_t           state;
  state_t           state_nx;
  shift_kind_t      sh_kind;
  logic [DSIZE-1:0] sh_reg;
  logic [SHW-1:0]   sh_cnt;
  logic [SHW-1:0]   amount;
  logic [DSIZE-1:0] step_f;
  logic             step_c;
  logic             is_shift;
  logic             start_shift;
  logic             sh_done;

  assign amount      = data_b[SHW-1:0];
  assign is_shift    = op[3] && op[2];
  assign start_shift = accept && is_shift && (amount != '0);
  assign sh_done     = (state == SHIFT) && (sh_cnt == SHW'(1));
  assign in_ready    = (state == IDLE) && (!out_valid || out_ready);
  assign busy        = (state == SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_shift) state_nx = SHIFT;
      SHIFT:   if (sh_done)     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One bit per cycle; step_c is the bit leaving the register this cycle.
  always_comb begin
    step_f = sh_reg;
    step_c = 1'b0;
    case (sh_kind)
      SK_SHL: begin step_f = {sh_reg[DSIZE-2:0], 1'b0};          step_c = sh_reg[DSIZE-1]; end
      SK_SHR: begin step_f = {1'b0, sh_reg[DSIZE-1:1]};          step_c = sh_reg[0];       end
      SK_ASR: begin step_f = {sh_reg[DSIZE-1], sh_reg[DSIZE-1:1]}; step_c = sh_reg[0];     end
      SK_ROR: begin step_f = {sh_reg[0], sh_reg[DSIZE-1:1]};     step_c = sh_reg[0];       end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_reg  <= '0;
      sh_cnt  <= '0;
      sh_kind <= SK_SHL;
    end else if (start_shift) begin
      sh_reg  <= data_a;
      sh_cnt  <= amount;
      sh_kind <= shift_kind_t'(op[1:0]);
    end else if (state == SHIFT) begin
      sh_reg  <= step_f;
      sh_cnt  <= sh_cnt - SHW'(1);
    end
  end

  // A zero-amount shift completes like any single-cycle op, passing a through.
  assign load = (accept && !start_shift) || sh_done;

  always_comb begin
    res_f = comb_f;
    res_c = comb_c;
    res_v = comb_v;
    if (sh_done) begin
      res_f = step_f;
      res_c = step_c;
      res_v = 1'b0;
    end else if (is_shift) begin
      res_f = data_a;
      res_c = 1'b0;
      res_v = 1'b0;
    end
  end
`else
  assign in_ready = !out_valid || out_ready;
  assign busy     = 1'b0;
  assign load     = accept;
  assign res_f    = comb_f;
  assign res_c    = comb_c;
  assign res_v    = comb_v;
`endif

  // Result register holds while the consumer stalls; a same-cycle load replaces it.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      out_valid <= 1'b0;
      f         <= '0;
      n         <= 1'b0;
      z         <= 1'b0;
      c         <= 1'b0;
      v         <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      f         <= res_f;
      n         <= res_f[DSIZE-1];
      z         <= (res_f == '0);
      c         <= res_c;
      v         <= res_v;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (DSIZE=16): directed cases plus random traffic against a reference model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [15:0] data_a;
  logic [15:0] data_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] f;
  logic        n, z, c, v;
  logic        busy;

  alu_seq #(.DSIZE(16), .OPSIZE(4), .SHW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .data_a    (data_a),
    .data_b    (data_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .n         (n),
    .z         (z),
    .c         (c),
    .v         (v),
    .busy      (busy)
  );

  typedef struct {
    logic [15:0] f;
    logic        n, z, c, v;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          busy_lo = 1;
  int          busy_hi = 0;
  int          last_acc = 0;
  bit          rdy_rand = 0;
  bit          fresh = 1;
  logic [19:0] held = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic over the opcode table.
  function automatic exp_t model(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
    exp_t               e;
    logic [15:0]        r;
    logic [15:0]        bp;
    logic signed [15:0] sa;
    int                 cin, sum, ssum, k;
    e.c = 1'b0; e.v = 1'b0; e.lat = 1; e.acc = 0;
    r = '0; bp = '0; cin = 0; sa = a; k = 0;
    if (!o[3]) begin
      case (o[2:0])
        3'd1: cin = 1;
        3'd2: bp = ~b;
        3'd3: begin bp = ~b; cin = 1; end
        3'd4: bp = b;
        3'd5: begin bp = b; cin = 1; end
        3'd7: bp = 16'hFFFF;
        default: ;
      endcase
      if (o[2:0] == 3'd6) begin
        r = b;
      end else begin
        sum  = int'(a) + int'(bp) + cin;
        ssum = int'($signed(a)) + int'($signed(bp)) + cin;
        r    = sum[15:0];
        e.c  = (sum > 65535);
        e.v  = (ssum > 32767) || (ssum < -32768);
      end
    end
`ifdef ALU_SEQ_SHIFT_EN
    else if (o[2]) begin
      k = int'(b[3:0]);
      e.lat = k + 1;
      case (o[1:0])
        2'd0: begin r = a << k;  e.c = (k > 0) ? a[16-k] : 1'b0; end
        2'd1: begin r = a >> k;  e.c = (k > 0) ? a[k-1]  : 1'b0; end
        2'd2: begin r = sa >>> k; e.c = (k > 0) ? a[k-1] : 1'b0; end
        default: begin r = (a >> k) | (a << (16 - k)); e.c = (k > 0) ? r[15] : 1'b0; end
      endcase
    end
`endif
    else begin
      case (o[1:0])
        2'd0: r = a & b;
        2'd1: r = a | b;
        2'd2: r = a ^ b;
        default: r = ~a;
      endcase
    end
    e.f = r;
    e.n = r[15];
    e.z = (r == 16'h0000);
    return e;
  endfunction

  task automatic drive(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    op       = o;
    data_a   = a;
    data_b   = b;
  endtask

  task automatic wait_accept();
    exp_t e;
    int   waited = 0;
    bit   ok = 1;
    @(negedge clk);
    while (!in_ready) begin
      waited++;
      if (waited > 100) begin
        check("accept_timeout", in_ready, 1);
        ok = 0;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      e = model(op, data_a, data_b);
      e.acc = cyc;
      last_acc = cyc;
      sb.push_back(e);
      if (e.lat > 1) begin
        busy_lo = cyc + 1;
        busy_hi = cyc + e.lat - 1;
      end
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
    @(posedge clk); #2;
    drive(o, a, b);
    wait_accept();
  endtask

  task automatic idle();
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic expect_now(input string name, input logic [15:0] fe, input logic [3:0] fl, input int lat);
    int waited = 0;
    @(negedge clk);
    while (!out_valid && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check({name, "_valid"}, out_valid, 1);
    check({name, "_f"}, f, fe);
    check({name, "_nzcv"}, {n, z, c, v}, fl);
    check({name, "_latency"}, cyc - last_acc, lat);
  endtask

  // Monitor: compares each newly presented result with the scoreboard head.
  initial forever begin
    exp_t e;
    bit   exp_busy;
    @(negedge clk);
    if (!rst_n) begin
      fresh = 1;
    end else begin
      exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
      check("busy", busy, exp_busy);
      if (exp_busy) check("in_ready_while_busy", in_ready, 0);
      if (out_valid) begin
        if (fresh) begin
          if (sb.size() == 0) begin
            check("unexpected_result", out_valid, 0);
          end else begin
            e = sb[0];
            check("sb_f", f, e.f);
            check("sb_nzcv", {n, z, c, v}, {e.n, e.z, e.c, e.v});
            check("sb_latency", cyc - e.acc, e.lat);
          end
          held = {f, n, z, c, v};
        end else begin
          check("hold_stable", {f, n, z, c, v}, held);
        end
        if (out_ready) begin
          if (sb.size() > 0) e = sb.pop_front();
          fresh = 1;
        end else begin
          fresh = 0;
        end
      end else begin
        fresh = 1;
      end
    end
  end

  initial forever begin
    @(posedge clk); #3;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    int waited;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; data_a = '0; data_b = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_f", f, 0);
    check("rst_nzcv", {n, z, c, v}, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_release", in_ready, 1);

    issue(OP_ADD, 16'h7FFF, 16'h0001); idle(); expect_now("add_ovf", 16'h8000, 4'b1001, 1);
    issue(OP_SUB, 16'h0005, 16'h0005); idle(); expect_now("sub_zero", 16'h0000, 4'b0110, 1);
    issue(OP_DEC, 16'h0000, 16'h1234); idle(); expect_now("dec_wrap", 16'hFFFF, 4'b1000, 1);
`ifdef ALU_SEQ_SHIFT_EN
    issue(OP_ASR, 16'h8004, 16'h0003); idle(); expect_now("asr3", 16'hF000, 4'b1010, 4);
    issue(OP_SHR, 16'h00F0, 16'h0F00); idle(); expect_now("shr0", 16'h00F0, 4'b0000, 1);
`else
    issue(OP_ASR, 16'h8004, 16'h0003); idle(); expect_now("op1110_xor", 16'h8007, 4'b1000, 1);
    issue(OP_SHR, 16'h00F0, 16'h0F00); idle(); expect_now("op1101_or", 16'h0FF0, 4'b0000, 1);
`endif

    // Backpressure: result held, then replaced with no bubble.
    @(posedge clk); #2;
    out_ready = 1'b0;
    issue(OP_ADD, 16'h1234, 16'h1111); idle(); expect_now("hold_first", 16'h2345, 4'b0000, 1);
    repeat (5) begin
      @(negedge clk);
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    drive(OP_XOR, 16'hFFFF, 16'h0F0F);
    wait_accept();
    idle();
    expect_now("no_bubble", 16'hF0F0, 4'b1000, 1);

    // Reset in the middle of a long shift.
    issue(OP_SHL, 16'h00C3, 16'd10); idle();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_f", f, 0);
    check("midrst_nzcv", {n, z, c, v}, 0);
    sb.delete();
    busy_lo = 1;
    busy_hi = 0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_midrst", in_ready, 1);
    issue(OP_AND, 16'hF0F0, 16'hFF00); idle(); expect_now("and_after_rst", 16'hF000, 4'b1000, 1);

    // Random traffic with random consumer stalls.
    rdy_rand = 1;
    for (int i = 0; i < 300; i++) begin
      issue(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    rdy_rand = 0;
    out_ready = 1'b1;
    waited = 0;
    while (sb.size() != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("drain_empty", sb.size(), 0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: DSIZE, 16, datapath width in bits (>= 4, power of two).
REQ-002 Parameter: OPSIZE, 4, opcode width; only 4 is supported.
REQ-003 Parameter: SHW, $clog2(DSIZE), shift-amount width taken from data_b[SHW-1:0].
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1 / in_ready  out  1  operation handshake.
REQ-007 op  in  OPSIZE / data_a, data_b  in  DSIZE  operation and operands, sampled on accept.
REQ-008 out_valid  out  1 / out_ready  in  1  result handshake.
REQ-009 f  out  DSIZE  result; n, z, c, v  out  1 each  negative, zero, carry, overflow flags.
REQ-010 busy  out  1  multi-cycle shift in progress.

Function
REQ-011 Accept SHALL occur when in_valid && in_ready; in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-012 Arithmetic (op[3]=0) SHALL compute f = a + B' + cin: 000 B'=0,cin=0; 001 0,1; 010 ~b,0; 011 ~b,1; 100 b,0; 101 b,1; 111 all-ones,0; 110 f=b.
REQ-013 Arithmetic c SHALL be bit DSIZE of the (DSIZE+1)-bit sum; v = (a[msb]==B'[msb]) && (f[msb]!=a[msb]); op 110 gives c=v=0.
REQ-014 Logic (op[3:2]=10) SHALL give op[1:0] 00 a&b, 01 a|b, 10 a^b, 11 ~a, with c=v=0.
REQ-015 Shift (op[3:2]=11) SHALL give 00 SHL, 01 SHR, 10 ASR, 11 ROR of a by data_b[SHW-1:0], v=0.
REQ-016 For every op n=f[DSIZE-1], z=(f==0).
REQ-017 Non-shift ops: f and flags registered, out_valid=1 on the cycle after accept (latency 1).
REQ-018 Shift ops: FSM IDLE->SHIFT on accept with amount>0, one bit per cycle, SHIFT->IDLE when the count reaches 0; out_valid rises amount+1 cycles after accept; amount 0 completes with latency 1, c=0.
REQ-019 Shift c SHALL equal the last bit shifted out (ROR: final f[msb]).
REQ-020 busy=1 exactly while state==SHIFT; in_ready=0 while busy.
REQ-021 While out_valid && !out_ready, f and flags SHALL hold stable.
REQ-022 out_ready and a new accept in the same cycle SHALL replace the result with no bubble; out_ready without accept clears out_valid.
REQ-023 All arithmetic wraps modulo 2^DSIZE; no saturation.

Reset
REQ-024 rst_n low SHALL immediately force state=IDLE, out_valid=0, busy=0, f=0, n=z=c=v=0, aborting any shift in flight.
REQ-025 in_ready SHALL be 1 on the first clock after rst_n release.

Configuration
REQ-026 Macro ALU_SEQ_SHIFT_EN defined: shift ops per REQ-015..REQ-020.
REQ-027 Macro undefined: op 11xx decodes as logic per op[1:0], latency 1, SHIFT state and busy logic absent (busy tied 0).

Structure
REQ-028 Package alu_seq_pkg SHALL hold opcode constants, the FSM state typedef (IDLE, SHIFT) and shift-kind encodings.
REQ-029 Single-cycle datapath (REQ-012..REQ-014, f/c/v) SHALL be sub-module alu_seq_comb; FSM, shifter and output register live in alu_seq.

Verification (DSIZE=16)
REQ-030 ADD op 0100 a=0x7FFF b=0x0001 -> next cycle out_valid=1, f=0x8000, n=1 z=0 c=0 v=1.
REQ-031 SUB op 0011 a=5 b=5 -> f=0x0000, z=1 c=1 v=0; DEC op 0111 a=0 -> f=0xFFFF, n=1 c=0 v=0.
REQ-032 ASR op 1110 a=0x8004 b=3 -> busy=1 for 3 cycles, out_valid 4 cycles after accept, f=0xF000, c=1 n=1.
REQ-033 Hold out_ready=0 with result valid -> in_ready=0, f stable 5 cycles; raise out_ready with in_valid=1 -> new result next cycle, out_valid never drops.
REQ-034 Assert rst_n=0 during SHL b=10 at cycle 4 -> same-cycle out_valid=0, busy=0, f=0; after release, AND op 1000 a=0xF0F0 b=0xFF00 -> f=0xF000.
REQ-035 Build without ALU_SEQ_SHIFT_EN: op 1101 a=0x00F0 b=0x0F00 -> latency 1, f=0x0FF0, busy stays 0.
